// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and helpers for the memory bus initiator
// Contents: controller state enum, byte-lane select encoding, byte extension helper.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_LOAD_CAPTURE,
        ST_RESP
    } state_t;

    // Value of byte_select naming which half of the memory word is addressed.
    localparam logic LANE_HI = 1'b1;
    localparam logic LANE_LO = 1'b0;

    function automatic logic [15:0] extend_byte(input logic [7:0] data_byte,
                                                 input logic       is_signed);
        return is_signed ? {{8{data_byte[7]}}, data_byte} : {8'h00, data_byte};
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - byte-lane select and extension of memory read data
// Ports:
//   i_rdata       raw 16-bit word from the memory
//   i_byte        1 = byte access (select a lane and extend), 0 = pass word through
//   i_byte_select lane select, LANE_HI picks bits [15:8]
//   i_signed      sign-extend the selected byte when 1, zero-extend when 0
//   o_data        aligned 16-bit load result
module mem_load_align
    import mem_bus_pkg::*;
(
    input  logic [15:0] i_rdata,
    input  logic        i_byte,
    input  logic        i_byte_select,
    input  logic        i_signed,
    output logic [15:0] o_data
);

    logic [7:0] w_lane;

    assign w_lane = (i_byte_select == LANE_HI) ? i_rdata[15:8] : i_rdata[7:0];
    assign o_data = i_byte ? extend_byte(w_lane, i_signed) : i_rdata;

endmodule

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - requester-side controller for the on-chip word memory bus
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              request handshake from the load/store stage
//   req_write/req_byte/req_signed    store vs load, byte vs word, byte-load extension
//   req_addr/req_wdata               byte address and store data
//   resp_valid/resp_ready            response handshake
//   resp_rdata/resp_err              load result (0 for stores/errors), error flag
//   mem_en/mem_we                    memory enable and write enable
//   mem_byte_enable/mem_byte_select  byte access and lane (1 = high byte)
//   mem_addr/mem_wdata/mem_rdata     word address, write data, read data
//   mem_wait                         memory stall
module mem_initiator
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [15:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_byte_enable,
    output logic              mem_byte_select,
    output logic [15:0]       mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_wait
);

    // Count value on which the next stalled cycle aborts the access.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_write;
    logic                r_byte;
    logic                r_signed;
    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_wdata;
    logic [15:0]         r_rdata;
    logic                r_err;
    logic [15:0]         r_cnt;

    logic                w_capture;
    logic [15:0]         w_rdata_next;
    logic                w_err_next;
    logic [15:0]         w_cnt_next;
    logic [15:0]         w_aligned;
    logic                w_access;
    logic [15:0]         w_word_addr;

    mem_load_align u_align (
        .i_rdata       (mem_rdata),
        .i_byte        (r_byte),
        .i_byte_select (r_addr[0]),
        .i_signed      (r_signed),
        .o_data        (w_aligned)
    );

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_rdata_next = r_rdata;
        w_err_next   = r_err;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_capture    = 1'b1;
                    w_rdata_next = 16'h0000;
                    if (!req_byte && req_addr[0]) begin
                        // Misaligned word access: answer with an error, never touch memory.
                        w_err_next   = 1'b1;
                        w_state_next = ST_RESP;
                    end else begin
                        w_err_next   = 1'b0;
                        w_cnt_next   = 16'h0000;
                        w_state_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_wait) begin
                    if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
                        w_err_next   = 1'b1;
                        w_rdata_next = 16'h0000;
                        w_cnt_next   = 16'h0000;
                        w_state_next = ST_RESP;
                    end else begin
                        w_cnt_next = r_cnt + 16'h0001;
                    end
                end else if (r_write) begin
                    w_state_next = ST_RESP;
                end else begin
                    w_state_next = ST_LOAD_CAPTURE;
                end
            end
            ST_LOAD_CAPTURE: begin
                // Read data is valid the cycle after the memory accepted the access.
                w_rdata_next = w_aligned;
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_write  <= 1'b0;
            r_byte   <= 1'b0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 16'h0000;
            r_rdata  <= 16'h0000;
            r_err    <= 1'b0;
            r_cnt    <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_write  <= req_write;
                r_byte   <= req_byte;
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
        end
    end

    assign w_access    = (r_state == ST_ACCESS);
    assign w_word_addr = 16'({1'b0, r_addr[ADDR_W-1:1]});

    // Every memory-side output is qualified by the ACCESS state so the bus
    // is quiet (all zero) whenever no access is in flight, including in reset.
    assign req_ready       = (r_state == ST_IDLE);
    assign resp_valid      = (r_state == ST_RESP);
    assign resp_rdata      = r_rdata;
    assign resp_err        = r_err;
    assign mem_en          = w_access;
    assign mem_we          = w_access & r_write;
    assign mem_byte_enable = w_access & r_byte;
    assign mem_byte_select = w_access & r_byte & r_addr[0];
    assign mem_addr        = w_access ? w_word_addr : 16'h0000;
    assign mem_wdata       = (w_access && r_write)
                           ? (r_byte ? {8'h00, r_wdata[7:0]} : r_wdata)
                           : 16'h0000;

endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - self-checking bench for mem_initiator
module tb_mem_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_byte, req_signed;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [15:0] resp_rdata;
    logic        mem_en, mem_we, mem_byte_enable, mem_byte_select, mem_wait;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic        req_valid2, req_ready2, resp_valid2, resp_ready2, resp_err2;
    logic [15:0] resp_rdata2;
    logic        mem_en2, mem_we2, mem_byte_enable2, mem_byte_select2, mem_wait2;
    logic [15:0] mem_addr2, mem_wdata2;

    logic [15:0] mem     [32];
    logic [15:0] ref_mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_initiator #(.ADDR_W(16), .TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
        .mem_we(mem_we), .mem_byte_enable(mem_byte_enable),
        .mem_byte_select(mem_byte_select), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_wait(mem_wait)
    );

    mem_initiator #(.ADDR_W(16), .TIMEOUT(3)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid2), .resp_ready(resp_ready2),
        .resp_rdata(resp_rdata2), .resp_err(resp_err2), .mem_en(mem_en2),
        .mem_we(mem_we2), .mem_byte_enable(mem_byte_enable2),
        .mem_byte_select(mem_byte_select2), .mem_addr(mem_addr2),
        .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata), .mem_wait(mem_wait2)
    );

    // Memory block: 32 words, commits on an enabled edge without wait,
    // ignores addresses outside its range (read data stays stale).
    always @(posedge clk) begin
        if (mem_en && !mem_wait && mem_addr < 16'd32) begin
            if (mem_we) begin
                if (mem_byte_enable) begin
                    if (mem_byte_select) mem[mem_addr[4:0]][15:8] <= mem_wdata[7:0];
                    else                 mem[mem_addr[4:0]][7:0]  <= mem_wdata[7:0];
                end else begin
                    mem[mem_addr[4:0]] <= mem_wdata;
                end
            end else begin
                mem_rdata <= mem[mem_addr[4:0]];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction: nw wait cycles on the memory, response held for hold cycles.
    task automatic do_req(input logic w, input logic b, input logic s,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int nw, input int hold);
        int          idx, cyc, en, waits_left, exp_lat, exp_en, bv;
        logic        mis, exp_err;
        logic [15:0] exp_rd, c_addr, c_wdata;
        logic        c_we, c_be, c_sel;
        idx     = int'(a) / 2;
        mis     = !b && (a % 2 == 1);
        exp_err = 1'b0;
        exp_rd  = 16'h0000;
        if (mis) begin
            exp_lat = 1; exp_en = 0; exp_err = 1'b1;
        end else if (w) begin
            exp_lat = 2 + nw; exp_en = 1 + nw;
            if (idx < 32) begin
                if (!b)              ref_mem[idx] = wd;
                else if (a % 2 == 1) ref_mem[idx] = (ref_mem[idx] % 256) + (wd % 256) * 256;
                else                 ref_mem[idx] = (ref_mem[idx] / 256) * 256 + (wd % 256);
            end
        end else begin
            exp_lat = 3 + nw; exp_en = 1 + nw;
            if (!b) begin
                exp_rd = ref_mem[idx];
            end else begin
                bv = (a % 2 == 1) ? int'(ref_mem[idx]) / 256 : int'(ref_mem[idx]) % 256;
                if (s && bv >= 128) bv = bv + 'hFF00;
                exp_rd = 16'(bv);
            end
        end
        @(negedge clk);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_write = w; req_byte = b; req_signed = s; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid  = 1'b0;
        cyc        = 1;
        en         = 0;
        waits_left = nw;
        c_addr = 16'h0; c_wdata = 16'h0; c_we = 1'b0; c_be = 1'b0; c_sel = 1'b0;
        while (!resp_valid && cyc < 60) begin
            if (mem_en) begin
                if (en == 0) begin
                    c_addr = mem_addr; c_wdata = mem_wdata; c_we = mem_we;
                    c_be = mem_byte_enable; c_sel = mem_byte_select;
                end
                en++;
                mem_wait = (waits_left > 0);
                if (waits_left > 0) waits_left--;
            end else begin
                mem_wait = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        mem_wait = 1'b0;
        check_eq("latency", cyc, exp_lat);
        check_eq("mem_en_cycles", en, exp_en);
        if (!mis) begin
            check_eq("mem_addr", c_addr, a / 2);
            check_eq("mem_ctrl", {c_we, c_be, c_sel}, {w, b, b & a[0]});
            if (w) check_eq("mem_wdata", c_wdata, b ? (wd % 256) : wd);
        end
        check_eq("resp_err", resp_err, exp_err);
        check_eq("resp_rdata", resp_rdata, exp_rd);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("hold_state", {resp_valid, req_ready, resp_err}, {1'b1, 1'b0, exp_err});
            check_eq("hold_rdata", resp_rdata, exp_rd);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("after_handshake", {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        int cyc, en;
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; resp_ready = 1'b0; mem_wait = 1'b0;
        req_valid2 = 1'b0; resp_ready2 = 1'b0; mem_wait2 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_handshake", {req_ready, resp_valid, resp_err}, 3'b100);
        check_eq("rst_rdata", resp_rdata, 16'h0);
        check_eq("rst_mem_ctrl", {mem_en, mem_we, mem_byte_enable, mem_byte_select}, 4'b0);
        check_eq("rst_mem_data", {mem_addr, mem_wdata}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) do_req(1'b1, 1'b0, 1'b0, 16'(i * 2), 16'($urandom), 0, 0);

        // Directed cases
        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 0, 0);
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 0);
        do_req(1'b1, 1'b1, 1'b0, 16'h0011, 16'hAB12, 0, 0);
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 0, 0);
        check_eq("byte_merge_ref", ref_mem[8], 16'h12EF);
        do_req(1'b1, 1'b0, 1'b0, 16'h0010, 16'h80FF, 0, 0);
        do_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 0, 0);
        do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, 0);
        do_req(1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000, 0, 0);
        do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 4, 0);
        do_req(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 0, 5);
        do_req(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h0055, 0, 0);

        // Reset asserted while an access is stalled in memory
        @(negedge clk);
        req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_wait  = 1'b1;
        check_eq("pre_rst_mem_en", {31'd0, mem_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_mid_mem_en", {31'd0, mem_en}, 32'd0);
        check_eq("rst_mid_handshake", {req_ready, resp_valid}, 2'b10);
        @(negedge clk);
        rst_n    = 1'b1;
        mem_wait = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_rst_idle", {req_ready, resp_valid, mem_en}, 3'b100);
        end

        // Timeout instance: memory stalls forever
        @(negedge clk);
        req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0010;
        req_valid2 = 1'b1; mem_wait2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        cyc = 1;
        en  = 0;
        while (!resp_valid2 && cyc < 60) begin
            if (mem_en2) en++;
            @(negedge clk);
            cyc++;
        end
        check_eq("to_latency", cyc, 4);
        check_eq("to_en_cycles", en, 3);
        check_eq("to_resp", {resp_err2, req_ready2, mem_en2}, 3'b100);
        check_eq("to_rdata", resp_rdata2, 16'h0);
        check_eq("to_mem_quiet", {mem_we2, mem_byte_enable2, mem_byte_select2, |mem_addr2, |mem_wdata2}, 5'b0);
        resp_ready2 = 1'b1;
        @(negedge clk);
        resp_ready2 = 1'b0;
        mem_wait2   = 1'b0;
        check_eq("to_after_handshake", {resp_valid2, req_ready2}, 2'b01);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 60; i++) begin
            do_req(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom_range(0, 63)),
                   16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
